// File: rtl/fb_port_arbiter.sv
// Framebuffer SPRAM port arbiter: buffered capture writes, prioritised
// scan reads with a bounded read burst so the write FIFO always drains.
module fb_port_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_BITS    = 14,
  parameter int DATA_BITS    = 16,
  parameter int MAX_RD_BURST = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [3:0]           wr_mask,
  output logic [7:0]           drop_count,
  input  logic                 rd_req,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_ack,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 ram_wen,
  output logic [ADDR_BITS-1:0] ram_wr_addr,
  output logic [DATA_BITS-1:0] ram_wr_data,
  output logic [3:0]           ram_wr_mask,
  output logic [ADDR_BITS-1:0] ram_rd_addr,
  input  logic [DATA_BITS-1:0] ram_rd_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MAX_RD_BURST + 1);

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
    logic [3:0]           mask;
  } wr_word_t;

  wr_word_t      fifo_q [FIFO_DEPTH];
  wr_word_t      head;
  wr_word_t      last_q;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [SW-1:0] starve_q;

  logic nonempty;
  logic force_wr;
  logic push;
  logic pop;
  logic rd_grant;

  assign nonempty = (count_q != '0);
  assign wr_ready = (count_q < CW'(FIFO_DEPTH));
  assign push     = wr_valid && wr_ready;
  assign force_wr = (starve_q == SW'(MAX_RD_BURST)) && nonempty;

  // Gated by reset so a held rd_req cannot ack while the block is in reset.
  assign rd_grant = reset_n && rd_req && !force_wr;
  assign pop      = !rd_grant && nonempty;
  assign head     = fifo_q[rptr_q];

  assign rd_ack      = rd_grant;
  assign rd_data     = ram_rd_data;
  assign ram_rd_addr = rd_grant ? rd_addr : '0;
  assign ram_wen     = pop;
  assign ram_wr_addr = pop ? head.addr : last_q.addr;
  assign ram_wr_data = pop ? head.data : last_q.data;
  assign ram_wr_mask = pop ? head.mask : last_q.mask;

  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wptr_q] <= {wr_addr, wr_data, wr_mask};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      if (push)
        wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        last_q <= head;
      end
      unique case (1'b1)
        (push && !pop): count_q <= count_q + 1'b1;
        (pop && !push): count_q <= count_q - 1'b1;
        default:        count_q <= count_q;
      endcase
    end
  end

  // Counts reads that overtook a waiting write; cleared on drain or write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      starve_q <= '0;
    else if (!nonempty || pop)
      starve_q <= '0;
    else if (rd_grant)
      starve_q <= starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rd_valid <= 1'b0;
    else
      rd_valid <= rd_grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_count <= '0;
    else if (wr_valid && !wr_ready && drop_count != 8'hFF)
      drop_count <= drop_count + 8'd1;
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: SPRAM model, write/read scoreboards,
// a table for the overflow/starvation sequence and hand-written corners.
`timescale 1ns/1ps
module tb_fb_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [13:0] wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  wr_mask;
  logic [7:0]  drop_count;
  logic        rd_req;
  logic [13:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        ram_wen;
  logic [13:0] ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic [3:0]  ram_wr_mask;
  logic [13:0] ram_rd_addr;
  logic [15:0] ram_rd_data;

  fb_port_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .drop_count  (drop_count),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .ram_wen     (ram_wen),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_mask (ram_wr_mask),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] addr;
    logic [15:0] data;
    logic [3:0]  mask;
  } wr_exp_t;

  typedef struct {
    bit          wv;
    logic [13:0] addr;
    logic [15:0] data;
    logic [3:0]  mask;
    bit          rq;
    logic [13:0] raddr;
    bit          acc;
    bit          e_ack;
    bit          e_wen;
    bit          e_rdy;
    logic [7:0]  e_drop;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  bit          wq_check = 1'b1;
  logic [15:0] mem [16384];
  wr_exp_t     wq [$];
  logic [15:0] rq [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SPRAM model: nibble-masked write, registered read.
  always @(posedge clk) begin : spram
    logic [15:0] w;
    if (ram_wen) begin
      w = mem[ram_wr_addr];
      for (int i = 0; i < 4; i++)
        if (ram_wr_mask[i])
          w[4*i +: 4] = ram_wr_data[4*i +: 4];
      mem[ram_wr_addr] <= w;
    end
    ram_rd_data <= mem[ram_rd_addr];
  end

  always @(negedge clk) begin : mon
    wr_exp_t e;
    if (reset_n === 1'b1) begin
      if (ram_wen === 1'b1 && wq_check) begin
        if (wq.size() == 0) begin
          chk("unexpected_wen", 32'(ram_wen), 32'(1'b0));
        end else begin
          e = wq.pop_front();
          chk("sb_wr_addr", 32'(ram_wr_addr), 32'(e.addr));
          chk("sb_wr_data", 32'(ram_wr_data), 32'(e.data));
          chk("sb_wr_mask", 32'(ram_wr_mask), 32'(e.mask));
        end
      end
      if (rd_ack === 1'b1) begin
        chk("sb_ram_rd_addr", 32'(ram_rd_addr), 32'(rd_addr));
        rq.push_back(mem[rd_addr]);
      end
      if (rd_valid === 1'b1) begin
        if (rq.size() == 0)
          chk("unexpected_rd_valid", 32'(rd_valid), 32'(1'b0));
        else
          chk("sb_rd_data", 32'(rd_data), 32'(rq.pop_front()));
      end
    end
  end

  task automatic drive(input bit wv, input logic [13:0] a,
                       input logic [15:0] d, input logic [3:0] m,
                       input bit rqv, input logic [13:0] ra);
    wr_valid = wv;
    wr_addr  = a;
    wr_data  = d;
    wr_mask  = m;
    rd_req   = rqv;
    rd_addr  = ra;
  endtask

  task automatic step(input bit wv, input logic [13:0] a,
                      input logic [15:0] d, input logic [3:0] m,
                      input bit rqv, input logic [13:0] ra);
    @(posedge clk);
    #1;
    drive(wv, a, d, m, rqv, ra);
  endtask

  task automatic push_exp(input logic [13:0] a, input logic [15:0] d,
                          input logic [3:0] m);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    e.mask = m;
    wq.push_back(e);
  endtask

  vec_t        tv [14];
  logic [13:0] ack_bits;
  logic [13:0] wen_bits;
  logic [13:0] rdy_bits;
  logic [13:0] ra;

  initial begin
    for (int i = 0; i < 16384; i++)
      mem[i] = 16'(i) ^ 16'hA5A5;

    // Overflow + starvation sequence, one row per cycle.
    ack_bits = 14'h01FE;
    wen_bits = 14'h1E00;
    rdy_bits = 14'h3C0F;
    for (int k = 0; k < 14; k++) begin
      tv[k].wv     = (k < 6);
      tv[k].addr   = 14'h0200 + 14'(k);
      tv[k].data   = (16'(k) * 16'h1111) ^ 16'hC0DE;
      tv[k].mask   = 4'(k + 1);
      tv[k].rq     = (k >= 1 && k <= 9);
      tv[k].raddr  = 14'h3000 + 14'(k);
      tv[k].acc    = (k < 4);
      tv[k].e_ack  = ack_bits[k];
      tv[k].e_wen  = wen_bits[k];
      tv[k].e_rdy  = rdy_bits[k];
      tv[k].e_drop = (k < 5) ? 8'd0 : (k == 5) ? 8'd1 : 8'd2;
    end

    reset_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("rst_wr_ready", 32'(wr_ready), 32'(1'b1));
    chk("rst_rd_ack", 32'(rd_ack), 32'(1'b0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(1'b0));
    chk("rst_ram_wen", 32'(ram_wen), 32'(1'b0));
    chk("rst_drop", 32'(drop_count), 32'(8'd0));

    // Single write then read-back.
    step(1'b1, 14'h0123, 16'hBEEF, 4'hF, 1'b0, '0);
    push_exp(14'h0123, 16'hBEEF, 4'hF);
    #1 chk("sw_wen_push_cycle", 32'(ram_wen), 32'(1'b0));
    step(1'b0, '0, '0, '0, 1'b0, '0);
    #1;
    chk("sw_wen", 32'(ram_wen), 32'(1'b1));
    chk("sw_addr", 32'(ram_wr_addr), 32'(14'h0123));
    chk("sw_data", 32'(ram_wr_data), 32'(16'hBEEF));
    chk("sw_mask", 32'(ram_wr_mask), 32'(4'hF));
    step(1'b0, '0, '0, '0, 1'b0, '0);
    #1;
    chk("sw_wen_off", 32'(ram_wen), 32'(1'b0));
    chk("sw_hold_addr", 32'(ram_wr_addr), 32'(14'h0123));
    chk("sw_hold_data", 32'(ram_wr_data), 32'(16'hBEEF));
    step(1'b0, '0, '0, '0, 1'b1, 14'h0123);
    #1 chk("sw_rd_ack", 32'(rd_ack), 32'(1'b1));
    step(1'b0, '0, '0, '0, 1'b0, '0);
    #1;
    chk("sw_rd_valid", 32'(rd_valid), 32'(1'b1));
    chk("sw_rd_data", 32'(rd_data), 32'(16'hBEEF));

    for (int k = 0; k < 14; k++) begin
      step(tv[k].wv, tv[k].addr, tv[k].data, tv[k].mask,
           tv[k].rq, tv[k].raddr);
      if (tv[k].acc)
        push_exp(tv[k].addr, tv[k].data, tv[k].mask);
      #1;
      chk($sformatf("v%0d_ack", k), 32'(rd_ack), 32'(tv[k].e_ack));
      chk($sformatf("v%0d_wen", k), 32'(ram_wen), 32'(tv[k].e_wen));
      chk($sformatf("v%0d_rdy", k), 32'(wr_ready), 32'(tv[k].e_rdy));
      chk($sformatf("v%0d_drop", k), 32'(drop_count), 32'(tv[k].e_drop));
    end
    chk("ovf_all_written", 32'(wq.size()), 32'(0));

    // Continuous reads with an empty FIFO.
    for (int j = 0; j < 100; j++) begin
      ra = 14'($urandom);
      step(1'b0, '0, '0, '0, 1'b1, ra);
      #1;
      chk("cr_ack", 32'(rd_ack), 32'(1'b1));
      chk("cr_wen", 32'(ram_wen), 32'(1'b0));
      if (j > 0)
        chk("cr_valid", 32'(rd_valid), 32'(1'b1));
    end
    step(1'b0, '0, '0, '0, 1'b0, '0);
    #1 chk("cr_valid_last", 32'(rd_valid), 32'(1'b1));
    step(1'b0, '0, '0, '0, 1'b0, '0);
    #1 chk("cr_valid_done", 32'(rd_valid), 32'(1'b0));

    // Reset with three buffered words and a read in flight.
    step(1'b1, 14'h0011, 16'h1111, 4'hF, 1'b0, '0);
    push_exp(14'h0011, 16'h1111, 4'hF);
    step(1'b1, 14'h0022, 16'h2222, 4'hF, 1'b1, 14'h0040);
    push_exp(14'h0022, 16'h2222, 4'hF);
    step(1'b1, 14'h0033, 16'h3333, 4'hF, 1'b1, 14'h0041);
    push_exp(14'h0033, 16'h3333, 4'hF);
    step(1'b0, '0, '0, '0, 1'b1, 14'h0042);
    #1 reset_n = 1'b0;
    wq.delete();
    rq.delete();
    #1;
    chk("mr_rd_ack", 32'(rd_ack), 32'(1'b0));
    chk("mr_rd_valid", 32'(rd_valid), 32'(1'b0));
    chk("mr_wen", 32'(ram_wen), 32'(1'b0));
    chk("mr_wr_ready", 32'(wr_ready), 32'(1'b1));
    chk("mr_drop", 32'(drop_count), 32'(8'd0));
    chk("mr_wr_addr", 32'(ram_wr_addr), 32'(14'h0));
    chk("mr_wr_data", 32'(ram_wr_data), 32'(16'h0));
    chk("mr_wr_mask", 32'(ram_wr_mask), 32'(4'h0));
    chk("mr_rd_addr", 32'(ram_rd_addr), 32'(14'h0));
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    reset_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step(1'b0, '0, '0, '0, 1'b0, '0);
      #1;
      chk("pr_wen", 32'(ram_wen), 32'(1'b0));
      chk("pr_rd_valid", 32'(rd_valid), 32'(1'b0));
      chk("pr_wr_ready", 32'(wr_ready), 32'(1'b1));
    end

    // Drop counter saturation under a starved, full FIFO.
    wq_check = 1'b0;
    for (int j = 0; j < 300; j++)
      step(1'b1, 14'($urandom), 16'($urandom), 4'hF, 1'b1, 14'($urandom));
    step(1'b0, '0, '0, '0, 1'b0, '0);
    #1 chk("sat_drop", 32'(drop_count), 32'(8'd255));
    repeat (10) step(1'b1, 14'h0, 16'h0, 4'hF, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b0, '0);
    #1 chk("sat_drop_hold", 32'(drop_count), 32'(8'd255));
    repeat (10) step(1'b0, '0, '0, '0, 1'b0, '0);
    #1 chk("sat_drained_wen", 32'(ram_wen), 32'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Sits directly upstream of the 32 KB single-port SPRAM framebuffer wrapper and produces all of its address, data, mask and write-enable inputs.
- Arbitrates between two clients:
  - a pixel-capture writer: a streaming push interface, already in the clk domain, that cannot stall;
  - a display-scan reader: request/ack, fixed one-cycle read latency.
- Writes are buffered in a small FIFO. Reads have priority, bounded by a starvation limit.

Parameters:
- FIFO_DEPTH, 4, write FIFO entries; power of two, minimum 2.
- ADDR_BITS, 14, SPRAM word address width.
- DATA_BITS, 16, SPRAM word width.
- MAX_RD_BURST, 8, maximum consecutive read grants while the FIFO is non-empty before one write slot is forced.

Ports:
- clk  in  1  single clock; drives all logic and the SPRAM.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  writer presents a word this cycle.
- wr_ready  out  1  FIFO not full.
- wr_addr  in  ADDR_BITS  write word address.
- wr_data  in  DATA_BITS  write data.
- wr_mask  in  4  nibble write mask.
- drop_count  out  8  saturating count of words dropped because the FIFO was full.
- rd_req  in  1  reader requests a read this cycle.
- rd_addr  in  ADDR_BITS  read word address.
- rd_ack  out  1  read granted this cycle (combinational).
- rd_valid  out  1  rd_data valid; asserted exactly one cycle after rd_ack.
- rd_data  out  DATA_BITS  read result.
- ram_wen  out  1  SPRAM write enable.
- ram_wr_addr  out  ADDR_BITS  SPRAM write address.
- ram_wr_data  out  DATA_BITS  SPRAM write data.
- ram_wr_mask  out  4  SPRAM write mask.
- ram_rd_addr  out  ADDR_BITS  SPRAM read address.
- ram_rd_data  in  DATA_BITS  SPRAM read data; registered inside the SPRAM, valid the cycle after the address.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO emptied.
  - drop_count=0, starvation counter=0.
  - rd_valid=0, wr_ready=1, rd_ack=0, ram_wen=0; ram_* addresses and data 0.
  - Reset asserted mid-operation discards pending FIFO words and any in-flight read; rd_valid must not assert on the cycle after reset releases.
- Push:
  - wr_valid && wr_ready: the word enters the FIFO at the clock edge.
  - wr_valid && !wr_ready: the word is dropped and drop_count increments, saturating at 255.
  - wr_ready = (count < FIFO_DEPTH). It is registered-count based and does not depend on a same-cycle pop.
- Arbitration is combinational each cycle. force_wr = (starve == MAX_RD_BURST) && fifo_nonempty.
  - rd_req && !force_wr: rd_ack=1, ram_wen=0, ram_rd_addr=rd_addr.
  - Otherwise, if fifo_nonempty: pop the FIFO head, ram_wen=1, ram_wr_addr/data/mask come from the head.
  - Otherwise: idle, ram_wen=0.
- Starvation counter:
  - Increments on each read grant while fifo_nonempty.
  - Resets to 0 on any write grant, or whenever the FIFO is empty.
  - Result: the reader sees at most one denied cycle per MAX_RD_BURST+1.
- Read return:
  - rd_valid is a register of rd_ack.
  - rd_data = ram_rd_data, passed through.
  - Back-to-back reads give one result per cycle.
- Simultaneous push and pop: count is unchanged and ordering is preserved. FIFO pointers wrap modulo FIFO_DEPTH.
- No read-after-write forwarding. A read to an address with a pending FIFO write returns the old SPRAM contents (accepted for framebuffer use).
- The ram_wr_* outputs hold their last values when ram_wen=0.

Test Plan:
- Reset release, no traffic -> wr_ready=1, rd_ack=0, rd_valid=0, ram_wen=0, drop_count=0.
- Single write: addr 0x0123, data 0xBEEF, mask 4'b1111, no reads.
  - Expect ram_wen=1 with those values in the next arbitration cycle, then ram_wen=0.
  - Then rd_req addr 0x0123 -> rd_ack same cycle; rd_valid with 0xBEEF one cycle later.
- Push 6 words on consecutive cycles while rd_req is held high, DEPTH=4, MAX_RD_BURST=8:
  - words 5 and 6 dropped, drop_count=2;
  - the first forced write occurs on the 9th read-request cycle, with rd_ack=0 that cycle;
  - all 4 buffered words are eventually written, in order.
- Continuous rd_req with an empty FIFO for 100 cycles -> rd_ack=1 every cycle; rd_valid follows by exactly 1 cycle; ram_wen never asserts.
- Assert reset_n low while the FIFO holds 3 words and a read is in flight:
  - all outputs take reset values immediately;
  - after release, no stale writes are issued and rd_valid stays 0.
- Push 300 words into a full, starved FIFO -> drop_count saturates at 255 and does not wrap.
